mul_share_arb: RTL and testbench

//  Shares one 8x8->16 sequential multiplier (start pulse / busy / result handshake) between two requesters, A and B.

---
 rtl/mul_share_arb.sv | 180 ++++++++++++++++++
 tb/tb_mul_share_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin front end sharing one sequential 8x8->16 multiplier between ports A and B.
// Define MUL_ARB_STATS_EN to enable the saturating per-port grant counters (stat_cnt_a/stat_cnt_b).
module mul_share_arb #(
    parameter int W_OP  = 8,
    parameter int W_RES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [W_OP-1:0]  reqa_a,
    input  logic [W_OP-1:0]  reqa_b,
    input  logic             reqa_start_i,
    output logic             reqa_busy_o,
    output logic [W_RES-1:0] reqa_y_bo,
    input  logic [W_OP-1:0]  reqb_a,
    input  logic [W_OP-1:0]  reqb_b,
    input  logic             reqb_start_i,
    output logic             reqb_busy_o,
    output logic [W_RES-1:0] reqb_y_bo,
    output logic [W_OP-1:0]  mul_a,
    output logic [W_OP-1:0]  mul_b,
    output logic             mul_start_o,
    input  logic             mul_busy_i,
    input  logic [W_RES-1:0] mul_y_bi,
    output logic             grant_o,
    output logic [15:0]      stat_cnt_a,
    output logic [15:0]      stat_cnt_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t           state_r;
    logic             pend_a_r;
    logic             pend_b_r;
    logic             last_r;
    logic             grant_r;
    logic             start_r;
    logic [W_OP-1:0]  hold_aa_r;
    logic [W_OP-1:0]  hold_ab_r;
    logic [W_OP-1:0]  hold_ba_r;
    logic [W_OP-1:0]  hold_bb_r;
    logic [W_OP-1:0]  mul_a_r;
    logic [W_OP-1:0]  mul_b_r;
    logic [W_RES-1:0] y_a_r;
    logic [W_RES-1:0] y_b_r;
    logic             cap_a_s;
    logic             cap_b_s;
    logic             issue_s;
    logic             win_s;

    // Start acceptance, issue condition and round-robin winner selection
    always_comb begin
        cap_a_s = reqa_start_i & ~pend_a_r;
        cap_b_s = reqb_start_i & ~pend_b_r;
        issue_s = (state_r == ST_IDLE) & (pend_a_r | pend_b_r) & ~mul_busy_i;
        if (pend_a_r && pend_b_r) begin
            win_s = ~last_r;
        end else begin
            win_s = pend_b_r;
        end
    end

    // Per-port operand hold registers, loaded only on an accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_aa_r <= {W_OP{1'b0}};
            hold_ab_r <= {W_OP{1'b0}};
            hold_ba_r <= {W_OP{1'b0}};
            hold_bb_r <= {W_OP{1'b0}};
        end else begin
            if (cap_a_s) begin
                hold_aa_r <= reqa_a;
                hold_ab_r <= reqa_b;
            end
            if (cap_b_s) begin
                hold_ba_r <= reqb_a;
                hold_bb_r <= reqb_b;
            end
        end
    end

    // Arbiter FSM: pending flags, multiplier drive, result routing and RR pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            pend_a_r <= 1'b0;
            pend_b_r <= 1'b0;
            last_r   <= 1'b1;
            grant_r  <= 1'b0;
            start_r  <= 1'b0;
            mul_a_r  <= {W_OP{1'b0}};
            mul_b_r  <= {W_OP{1'b0}};
            y_a_r    <= {W_RES{1'b0}};
            y_b_r    <= {W_RES{1'b0}};
        end else begin
            if (cap_a_s) begin
                pend_a_r <= 1'b1;
            end
            if (cap_b_s) begin
                pend_b_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        mul_a_r <= win_s ? hold_ba_r : hold_aa_r;
                        mul_b_r <= win_s ? hold_bb_r : hold_ab_r;
                        start_r <= 1'b1;
                        grant_r <= win_s;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_r <= 1'b0;
                    state_r <= ST_GAP;
                end
                // Multiplier busy rises one edge after start; skip a cycle before trusting it
                ST_GAP: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mul_busy_i) begin
                        if (grant_r) begin
                            y_b_r    <= mul_y_bi;
                            pend_b_r <= 1'b0;
                        end else begin
                            y_a_r    <= mul_y_bi;
                            pend_a_r <= 1'b0;
                        end
                        last_r  <= grant_r;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MUL_ARB_STATS_EN
    logic [15:0] cnt_a_r;
    logic [15:0] cnt_b_r;

    // Saturating grant counters, advanced on each issue to the winning port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_a_r <= 16'd0;
            cnt_b_r <= 16'd0;
        end else begin
            if (issue_s && !win_s && (cnt_a_r != 16'hFFFF)) begin
                cnt_a_r <= cnt_a_r + 16'd1;
            end
            if (issue_s && win_s && (cnt_b_r != 16'hFFFF)) begin
                cnt_b_r <= cnt_b_r + 16'd1;
            end
        end
    end

    assign stat_cnt_a = cnt_a_r;
    assign stat_cnt_b = cnt_b_r;
`else
    assign stat_cnt_a = 16'd0;
    assign stat_cnt_b = 16'd0;
`endif

    assign reqa_busy_o = pend_a_r;
    assign reqb_busy_o = pend_b_r;
    assign reqa_y_bo   = y_a_r;
    assign reqb_y_bo   = y_b_r;
    assign mul_a       = mul_a_r;
    assign mul_b       = mul_b_r;
    assign mul_start_o = start_r;
    assign grant_o     = grant_r;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: transaction-level reference model plus directed scenarios.
// Builds with or without MUL_ARB_STATS_EN.
module tb_mul_share_arb;

`ifdef MUL_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  reqa_a, reqa_b, reqb_a, reqb_b;
    logic        reqa_start_i, reqb_start_i;
    logic        reqa_busy_o, reqb_busy_o;
    logic [15:0] reqa_y_bo, reqb_y_bo;
    logic [7:0]  mul_a, mul_b;
    logic        mul_start_o;
    logic        mul_busy_i;
    logic [15:0] mul_y_bi;
    logic        grant_o;
    logic [15:0] stat_cnt_a, stat_cnt_b;

    always #5 clk_i = ~clk_i;

    mul_share_arb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .reqa_a(reqa_a), .reqa_b(reqa_b), .reqa_start_i(reqa_start_i),
        .reqa_busy_o(reqa_busy_o), .reqa_y_bo(reqa_y_bo),
        .reqb_a(reqb_a), .reqb_b(reqb_b), .reqb_start_i(reqb_start_i),
        .reqb_busy_o(reqb_busy_o), .reqb_y_bo(reqb_y_bo),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start_o(mul_start_o),
        .mul_busy_i(mul_busy_i), .mul_y_bi(mul_y_bi),
        .grant_o(grant_o), .stat_cnt_a(stat_cnt_a), .stat_cnt_b(stat_cnt_b)
    );

    // Multiplier model: busy from the edge after start for mul_len cycles, product held afterwards
    logic        mul_busy_r = 1'b0;
    logic [15:0] prod_r     = 16'd0;
    int          rem_r      = 0;
    int          mul_len    = 5;
    logic        force_busy = 1'b0;
    logic        mb_at_edge = 1'b0;
    assign mul_busy_i = mul_busy_r | force_busy;
    assign mul_y_bi   = prod_r;

    always @(posedge clk_i) begin
        if (mul_start_o) begin
            mul_busy_r <= 1'b1;
            rem_r      <= mul_len - 1;
            prod_r     <= {8'd0, mul_a} * {8'd0, mul_b};
        end else if (mul_busy_r) begin
            if (rem_r == 0) mul_busy_r <= 1'b0;
            else            rem_r <= rem_r - 1;
        end
    end

    always @(posedge clk_i) mb_at_edge <= mul_busy_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference model state: one pending op per port, one op in flight, last owner
    int          cyc = 0;
    bit          m_pend [2];
    logic [7:0]  m_ha [2];
    logic [7:0]  m_hb [2];
    logic [15:0] m_y [2];
    bit          m_last, m_grant, m_infl, m_port;
    int          m_issue_cyc;
    int          m_cnt [2];
    int          cap_cyc [2];
    int          lat [2];
    int          n_issue = 0;
    bit          hist [$];
    bit          pa0, pb0, done_e, issue_e, w;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (!rst_ni) begin
                for (int p = 0; p < 2; p++) begin
                    m_pend[p] = 1'b0; m_y[p] = 16'd0; m_cnt[p] = 0;
                end
                m_last = 1'b1; m_grant = 1'b0; m_infl = 1'b0;
                check("rst_busy", {reqa_busy_o, reqb_busy_o}, 2'b00);
                check("rst_y", {reqa_y_bo, reqb_y_bo}, 32'd0);
                check("rst_mul", {mul_start_o, grant_o, mul_a, mul_b}, 18'd0);
                check("rst_stat", {stat_cnt_a, stat_cnt_b}, 32'd0);
            end else begin
                pa0 = m_pend[0];
                pb0 = m_pend[1];
                done_e  = m_infl && (cyc >= m_issue_cyc + 3) && !mb_at_edge;
                issue_e = !m_infl && (pa0 || pb0) && !mb_at_edge;
                if (done_e) begin
                    m_pend[m_port] = 1'b0;
                    m_y[m_port]    = {8'd0, m_ha[m_port]} * {8'd0, m_hb[m_port]};
                    m_infl         = 1'b0;
                    m_last         = m_port;
                    lat[m_port]    = cyc - cap_cyc[m_port];
                end
                check("mul_start", mul_start_o, issue_e);
                if (issue_e) begin
                    w = (pa0 && pb0) ? !m_last : pb0;
                    m_infl = 1'b1; m_port = w; m_issue_cyc = cyc; m_grant = w;
                    if (m_cnt[w] < 65535) m_cnt[w]++;
                    hist.push_back(w);
                    n_issue++;
                    check("mul_ops", {mul_a, mul_b}, {m_ha[w], m_hb[w]});
                end
                if (reqa_start_i && !pa0) begin
                    m_pend[0] = 1'b1; m_ha[0] = reqa_a; m_hb[0] = reqa_b; cap_cyc[0] = cyc;
                end
                if (reqb_start_i && !pb0) begin
                    m_pend[1] = 1'b1; m_ha[1] = reqb_a; m_hb[1] = reqb_b; cap_cyc[1] = cyc;
                end
                check("busy", {reqa_busy_o, reqb_busy_o}, {m_pend[0], m_pend[1]});
                check("y_a", reqa_y_bo, m_y[0]);
                check("y_b", reqb_y_bo, m_y[1]);
                check("grant", grant_o, m_grant);
                check("stat", {stat_cnt_a, stat_cnt_b},
                      STATS_ON ? {m_cnt[0][15:0], m_cnt[1][15:0]} : 32'd0);
            end
        end
    end

    // Stimulus: inputs change only on the falling edge
    bit auto_a = 1'b0, auto_b = 1'b0, rnd = 1'b0;

    task automatic tick();
        @(negedge clk_i);
        reqa_start_i = 1'b0;
        reqb_start_i = 1'b0;
        if (auto_a && !reqa_busy_o) begin
            reqa_start_i = 1'b1; reqa_a = 8'($urandom); reqa_b = 8'($urandom);
        end
        if (auto_b && !reqb_busy_o) begin
            reqb_start_i = 1'b1; reqb_a = 8'($urandom); reqb_b = 8'($urandom);
        end
        if (rnd) begin
            if ($urandom_range(0, 3) == 0) begin
                reqa_start_i = 1'b1; reqa_a = 8'($urandom); reqa_b = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                reqb_start_i = 1'b1; reqb_a = 8'($urandom); reqb_b = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) mul_len = $urandom_range(1, 7);
        end
    endtask

    task automatic drive(input bit sa, input bit sb, input logic [7:0] aa, input logic [7:0] ab,
                         input logic [7:0] ba, input logic [7:0] bb);
        reqa_start_i = sa; reqa_a = aa; reqa_b = ab;
        reqb_start_i = sb; reqb_a = ba; reqb_b = bb;
    endtask

    task automatic wait_idle();
        int k = 0;
        tick();
        while ((reqa_busy_o || reqb_busy_o) && k < 300) begin
            tick();
            k++;
        end
        check("idle_timeout", k < 300, 1'b1);
    endtask

    task automatic do_reset();
        tick();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    int n0;
    logic [7:0] seq;

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        rst_ni = 1'b1;

        // 1: A alone, 3*5
        drive(1'b1, 1'b0, 8'd3, 8'd5, 8'd0, 8'd0);
        tick();
        check("t1_busy_next", reqa_busy_o, 1'b1);
        wait_idle();
        check("t1_ya", reqa_y_bo, 16'd15);
        check("t1_yb", reqb_y_bo, 16'd0);
        check("t1_grant", grant_o, 1'b0);
        check("t1_latency", lat[0], 32'd8);

        // 2: simultaneous starts, A wins first tie after reset
        do_reset();
        n0 = n_issue;
        drive(1'b1, 1'b1, 8'd3, 8'd7, 8'd10, 8'd10);
        wait_idle();
        check("t2_ya", reqa_y_bo, 16'd21);
        check("t2_yb", reqb_y_bo, 16'd100);
        check("t2_starts", n_issue - n0, 32'd2);
        check("t2_order", {hist[n0], hist[n0 + 1]}, 2'b01);

        // 3: both ports saturating, grants must alternate
        do_reset();
        n0 = n_issue;
        auto_a = 1'b1; auto_b = 1'b1;
        for (int k = 0; k < 1000 && (n_issue - n0) < 8; k++) tick();
        auto_a = 1'b0; auto_b = 1'b0;
        wait_idle();
        check("t3_count", (n_issue - n0) >= 8, 1'b1);
        seq = 8'd0;
        for (int i = 0; i < 8; i++) if (n0 + i < hist.size()) seq[i] = hist[n0 + i];
        check("t3_seq", seq, 8'hAA);

        // 4: second start while busy is ignored
        n0 = n_issue;
        drive(1'b1, 1'b0, 8'd2, 8'd2, 8'd0, 8'd0);
        tick();
        tick();
        check("t4_busy", reqa_busy_o, 1'b1);
        drive(1'b1, 1'b0, 8'd9, 8'd9, 8'd0, 8'd0);
        wait_idle();
        check("t4_ya", reqa_y_bo, 16'd4);
        check("t4_grants", n_issue - n0, 32'd1);

        // 6: grant statistics
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 8'(i + 1), 8'd3, 8'd0, 8'd0);
            else       drive(1'b0, 1'b1, 8'd0, 8'd0, 8'(i), 8'd4);
            wait_idle();
        end
        check("t6_stat_a", stat_cnt_a, STATS_ON ? 16'd3 : 16'd0);
        check("t6_stat_b", stat_cnt_b, STATS_ON ? 16'd2 : 16'd0);

        // 5: reset during WAIT, multiplier still busy after release
        do_reset();
        drive(1'b1, 1'b0, 8'd6, 8'd6, 8'd0, 8'd0);
        for (int k = 0; k < 50 && !mul_busy_i; k++) tick();
        tick();
        tick();
        rst_ni = 1'b0;
        force_busy = 1'b1;
        tick();
        check("t5_rst_busy", reqa_busy_o, 1'b0);
        check("t5_rst_ya", reqa_y_bo, 16'd0);
        tick();
        rst_ni = 1'b1;
        n0 = n_issue;
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd4, 8'd4);
        repeat (3) tick();
        check("t5_no_issue", n_issue - n0, 32'd0);
        check("t5_held_start", mul_start_o, 1'b0);
        force_busy = 1'b0;
        wait_idle();
        check("t5_issue", n_issue - n0, 32'd1);
        check("t5_ya", reqa_y_bo, 16'd0);
        check("t5_yb", reqb_y_bo, 16'd16);

        // Randomized traffic with varying multiplier latency
        do_reset();
        rnd = 1'b1;
        repeat (2000) tick();
        rnd = 1'b0;
        mul_len = 5;
        wait_idle();
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
